// File: rtl/fetch_pkg.sv
// Shared pipeline definitions: opcode constants, the bubble instruction and the fetch FSM states.
package fetch_pkg;

  localparam int OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_NOP = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_ALU = 6'h01;
  localparam logic [OPCODE_W-1:0] OP_LDI = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_LD  = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_ST  = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BR  = 6'h05;

  // NOP opcode with every operand/control field zero, so decode drives nothing active.
  localparam logic [15:0] BUBBLE_INSTR = {OP_NOP, 10'h000};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
interface fetch_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_valid;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_valid);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_valid);
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry word+pc buffer that parks a fetched word while the IF/ID register is stalled.
module fetch_hold_buf #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [INSTR_W-1:0] word_in,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [INSTR_W-1:0] word,
  output logic [ADDR_W-1:0]  pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
      pc   <= '0;
    end else if (load) begin
      word <= word_in;
      pc   <= pc_in;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding memory requests, IF/ID register, stall buffer, immediate capture.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/bubble counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  fetch_if.master            bus,
  input  logic               stall,
  input  logic               flush,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] imm_word,
  output logic               imm_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_bubbles
`endif
);

  localparam logic [INSTR_W-1:0] BUBBLE = {OP_NOP, {(INSTR_W-OPCODE_W){1'b0}}};

  fetch_state_t       state, state_nxt;
  logic [ADDR_W-1:0]  pc;
  logic               imm_pending;
  logic               accept, have_word, take_imm, buf_load;
  logic [INSTR_W-1:0] hold_word, word_sel;
  logic [ADDR_W-1:0]  hold_pc, pc_sel;

  fetch_hold_buf #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .load    (buf_load),
    .word_in (bus.imem_rdata),
    .pc_in   (pc),
    .word    (hold_word),
    .pc      (hold_pc)
  );

  assign bus.imem_req  = (state == ST_REQ);
  assign bus.imem_addr = pc;

  // A word is available either straight off the bus or from the stall buffer.
  assign accept    = (state == ST_REQ) && bus.imem_valid;
  assign have_word = accept || (state == ST_HOLD);
  assign word_sel  = (state == ST_HOLD) ? hold_word : bus.imem_rdata;
  assign pc_sel    = (state == ST_HOLD) ? hold_pc : pc;
  assign take_imm  = have_word && (flush || imm_pending);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    buf_load  = 1'b0;
    unique case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ: begin
        if (accept && !take_imm && stall) begin
          state_nxt = ST_HOLD;
          buf_load  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (take_imm || !stall) state_nxt = ST_REQ;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      imm_pending <= 1'b0;
      imm_word    <= '0;
      imm_valid   <= 1'b0;
      if_id_instr <= BUBBLE;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else begin
      imm_valid <= 1'b0;
      if (accept) pc <= pc + ADDR_W'(1);
      // Immediates never enter IF/ID as valid; flush outranks stall on the register.
      if (take_imm) begin
        imm_word    <= word_sel;
        imm_valid   <= 1'b1;
        imm_pending <= 1'b0;
        if_id_instr <= BUBBLE;
        if_id_pc    <= pc_sel;
        if_id_valid <= 1'b0;
      end else if (flush && !imm_pending) begin
        imm_pending <= 1'b1;
        if_id_instr <= BUBBLE;
        if_id_valid <= 1'b0;
      end else if (!stall) begin
        if (have_word) begin
          if_id_instr <= word_sel;
          if_id_pc    <= pc_sel;
          if_id_valid <= 1'b1;
        end else begin
          if_id_instr <= BUBBLE;
          if_id_valid <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (accept && !take_imm) perf_fetched <= sat_inc16(perf_fetched);
      if ((state != ST_IDLE) && !if_id_valid) perf_bubbles <= sat_inc16(perf_bubbles);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-programmable memory model plus a narrow-address instance for pc wrap.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst, stall, flush;
  int   lat = 1;
  int   cnt = 0;
  logic [15:0] addr_q;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  fetch_if #(.ADDR_W(16), .INSTR_W(16)) bus ();
  fetch_if #(.ADDR_W(3),  .INSTR_W(16)) bus_w ();

  logic [15:0] if_id_instr, imm_word, w_instr, w_imm;
  logic [15:0] if_id_pc;
  logic [2:0]  w_pc;
  logic        if_id_valid, imm_valid, w_valid, w_imm_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched, perf_bubbles, w_pf, w_pb;
`endif

  fetch_unit #(.ADDR_W(16), .INSTR_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stall(stall), .flush(flush),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
    .imm_word(imm_word), .imm_valid(imm_valid)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  fetch_unit #(.ADDR_W(3), .INSTR_W(16)) dut_w (
    .clk(clk), .rst(rst), .bus(bus_w), .stall(1'b0), .flush(1'b0),
    .if_id_instr(w_instr), .if_id_pc(w_pc), .if_id_valid(w_valid),
    .imm_word(w_imm), .imm_valid(w_imm_valid)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(w_pf), .perf_bubbles(w_pb)
`endif
  );

  // Memory: mem[a] = a + 0x1000, response 'lat' cycles after the request is first seen.
  always @(posedge clk) begin
    bus.imem_valid <= 1'b0;
    if (rst) begin
      cnt <= 0;
    end else if (cnt != 0) begin
      if (cnt == 1) begin
        bus.imem_valid <= 1'b1;
        bus.imem_rdata <= addr_q + 16'h1000;
      end
      cnt <= cnt - 1;
    end else if (bus.imem_req && !bus.imem_valid) begin
      addr_q <= bus.imem_addr;
      if (lat == 1) begin
        bus.imem_valid <= 1'b1;
        bus.imem_rdata <= bus.imem_addr + 16'h1000;
      end else begin
        cnt <= lat - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) bus_w.imem_valid <= 1'b0;
    else     bus_w.imem_valid <= bus_w.imem_req && !bus_w.imem_valid;
    bus_w.imem_rdata <= {13'h0, bus_w.imem_addr};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic next_ifid(input string tag, input logic [15:0] ei, input logic [15:0] ep);
    bit found = 1'b0;
    for (int i = 0; i < 24 && !found; i++) begin
      @(negedge clk);
      if (if_id_valid) found = 1'b1;
    end
    check({tag, "_seen"}, 32'(found), 32'd1);
    check({tag, "_instr"}, 32'(if_id_instr), 32'(ei));
    check({tag, "_pc"}, 32'(if_id_pc), 32'(ep));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"},   32'(bus.imem_req), 32'd0);
    check({tag, "_addr"},  32'(bus.imem_addr), 32'd0);
    check({tag, "_instr"}, 32'(if_id_instr), 32'h0000);
    check({tag, "_pc"},    32'(if_id_pc), 32'd0);
    check({tag, "_valid"}, 32'(if_id_valid), 32'd0);
    check({tag, "_immw"},  32'(imm_word), 32'd0);
    check({tag, "_immv"},  32'(imm_valid), 32'd0);
  endtask

  initial begin
    bit found;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; lat = 1;
    repeat (3) @(negedge clk);
    check_reset("rst0");
    rst = 1'b0;
    @(negedge clk);
    check("req_first", 32'(bus.imem_req), 32'd1);
    check("addr_first", 32'(bus.imem_addr), 32'd0);

    next_ifid("seq0", 16'h1000, 16'd0);
    next_ifid("seq1", 16'h1001, 16'd1);
    next_ifid("seq2", 16'h1002, 16'd2);
    next_ifid("seq3", 16'h1003, 16'd3);
    next_ifid("seq4", 16'h1004, 16'd4);

    // Stall across the acceptance of address 5.
    stall = 1'b1;
    @(negedge clk);
    check("stl_hold_instr", 32'(if_id_instr), 32'h1004);
    check("stl_hold_valid", 32'(if_id_valid), 32'd1);
    @(negedge clk);
    check("stl_hold1_req", 32'(bus.imem_req), 32'd0);
    check("stl_hold1_instr", 32'(if_id_instr), 32'h1004);
    @(negedge clk);
    check("stl_hold2_req", 32'(bus.imem_req), 32'd0);
    check("stl_hold2_instr", 32'(if_id_instr), 32'h1004);
    stall = 1'b0;
    @(negedge clk);
    check("stl_rel_instr", 32'(if_id_instr), 32'h1005);
    check("stl_rel_pc", 32'(if_id_pc), 32'd5);
    check("stl_rel_valid", 32'(if_id_valid), 32'd1);
    check("stl_rel_addr", 32'(bus.imem_addr), 32'd6);
    next_ifid("seq6", 16'h1006, 16'd6);

    // Flush coinciding with acceptance of address 7.
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_immv", 32'(imm_valid), 32'd1);
    check("fl_immw", 32'(imm_word), 32'h1007);
    check("fl_valid", 32'(if_id_valid), 32'd0);
    @(negedge clk);
    check("fl_pulse", 32'(imm_valid), 32'd0);
    next_ifid("seq8", 16'h1008, 16'd8);

    // Flush with no word available (latency 4); a second flush while pending must not stack.
    lat = 4;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    check("pend_immv", 32'(imm_valid), 32'd0);
    check("pend_valid", 32'(if_id_valid), 32'd0);
    stall = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (imm_valid) found = 1'b1;
    end
    check("pend_seen", 32'(found), 32'd1);
    check("pend_immw", 32'(imm_word), 32'h1009);
    check("pend_req", 32'(bus.imem_req), 32'd1);
    check("pend_addr", 32'(bus.imem_addr), 32'd10);
    check("pend_ifv", 32'(if_id_valid), 32'd0);
    stall = 1'b0;
    @(negedge clk);
    check("pend_pulse", 32'(imm_valid), 32'd0);
    next_ifid("seq10", 16'h100A, 16'd10);

    // Reset while a request is outstanding.
    @(negedge clk);
    check("prerst_req", 32'(bus.imem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst1");
    rst = 1'b0; lat = 1;
    next_ifid("post_rst", 16'h1000, 16'd0);

    // Narrow-address instance: pc 7 wraps to 0.
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (w_valid && (w_pc == 3'd7)) found = 1'b1;
    end
    check("wrap_seen7", 32'(found), 32'd1);
    check("wrap_addr", 32'(bus_w.imem_addr), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (w_valid) found = 1'b1;
    end
    check("wrap_seen0", 32'(found), 32'd1);
    check("wrap_pc", 32'(w_pc), 32'd0);
    check("wrap_instr", 32'(w_instr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
